cache_l2_control: RTL
=====================

# cache_l2_control

Sequencing FSM for the two-way L2 cache datapath (`cache_l2_datapath`). It sits between the L1/arbiter-side request port and physical memory. It turns datapath status (`hit`, `replace`, `dirty`) into the datapath select and write strobes, and into the pmem read/write handshake. It also keeps saturating hit, miss and writeback counters for performance debug.

## Interface
Parameters:
- `CNT_WIDTH`, 16: width of each performance counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  upstream read request; held until `mem_resp`.
- `mem_write`  in  1  upstream write request; held until `mem_resp`.
- `mem_resp`  out  1  one-cycle completion pulse to upstream.
- `hit`  in  1  datapath: lookup hit in either way.
- `replace`  in  1  datapath: both ways valid at index, so a victim is evicted.
- `dirty`  in  1  datapath: selected victim way is dirty.
- `pmem_we`  out  1  datapath: write fill line, tag and valid into the victim way.
- `pmarmux_sel`  out  1  datapath: 0 = request tag (fetch), 1 = victim tag (writeback).
- `datamux_sel`  out  1  datapath: 0 = `pmem_rdata` (fill), 1 = merged write data (write hit).
- `load_addr`  out  1  datapath: load the registered pmem address.
- `pmem_read`  out  1  physical memory read request, level, held until `pmem_resp`.
- `pmem_write`  out  1  physical memory write request, level, held until `pmem_resp`.
- `pmem_resp`  in  1  physical memory completion, one cycle.
- `stats_clr`  in  1  synchronous clear of all counters.
- `hit_cnt`, `miss_cnt`, `wb_cnt`  out  `CNT_WIDTH`  saturating performance counters.

## Operation
- States: `IDLE`, `CHECK`, `WRITEBACK`, `FETCH`. Reset state is `IDLE`.
- Reset value of every output is 0. All strobes (`mem_resp`, `pmem_we`, `load_addr`, `pmem_read`, `pmem_write`) and both selects are decoded from state and inputs; their default is 0.
- `IDLE`: if `mem_read | mem_write`, go to `CHECK`; otherwise stay.
- `CHECK`:
  - Hit: `mem_resp=1` and `datamux_sel=mem_write`, so a write hit is stored by the datapath this cycle. Next state is `IDLE`.
  - Miss with `replace & dirty`: `load_addr=1`, `pmarmux_sel=1`. Next state is `WRITEBACK`.
  - Miss otherwise: `load_addr=1`, `pmarmux_sel=0`. Next state is `FETCH`.
  - No request present (it was dropped): go to `IDLE` with no `mem_resp`.
- `WRITEBACK`: `pmem_write=1` while in state.
  - On `pmem_resp`: `load_addr=1`, `pmarmux_sel=0`. Next state is `FETCH`.
- `FETCH`: `pmem_read=1` while in state.
  - On `pmem_resp`: `pmem_we=1`, `datamux_sel=0`. Next state is `CHECK`, where the re-lookup hits.
- `mem_read` and `mem_write` both high: treated as a write.
- `pmem_resp` outside `WRITEBACK` and `FETCH` is ignored.
- A request dropped mid-miss does not abort the miss. The pmem transaction and the fill complete, then `CHECK` returns to `IDLE`.
- A register `miss_pending` is set on a miss in `CHECK` and cleared in `IDLE`.
- Counters:
  - `hit_cnt` increments on a `CHECK` hit with `miss_pending=0`.
  - `miss_cnt` increments on a `CHECK` miss.
  - `wb_cnt` increments on entry to `WRITEBACK`.
  - All counters saturate at all-ones.
  - `stats_clr` takes priority over an increment in the same cycle.
- `rst_n` low at any point: immediate return to `IDLE`, counters to 0, every output to 0. An in-flight pmem transaction is abandoned.

## Timing
- Hit: request seen in `IDLE` at cycle 0; `mem_resp` at cycle 1. Back-to-back hits complete one every 2 cycles.
- Clean miss, with pmem latency L (the first `pmem_read` cycle to `pmem_resp`, inclusive):
  - `CHECK` at cycle 1, `FETCH` from cycle 2.
  - Fill at cycle 1+L.
  - `mem_resp` at cycle 2+L.
- Dirty miss, with writeback latency W: `mem_resp` at cycle 2+W+L.
- `load_addr` always precedes the first pmem request cycle by exactly one cycle. The pmem address register is therefore stable while a request is high.

## Structure
- Package `cache_l2_types`: state enum `l2_ctrl_state_t` and the `pmarmux_sel`/`datamux_sel` encodings as named constants.
- One sub-module: `sat_counter` (parameterised width, `inc`, `clr`), instantiated three times.

## Test plan
- Read hit: `hit=1`, `mem_read` held → `mem_resp` at cycle 1, no pmem activity, `hit_cnt=1`.
- Clean miss: `hit=0`, `replace=0`, pmem latency 4 → `load_addr` at cycle 1, `pmem_read` cycles 2–5, `pmem_we` at cycle 5, `mem_resp` at cycle 6. Counters: `miss_cnt=1`, `hit_cnt=0`.
- Dirty miss: `replace=dirty=1`, W=3, L=3 → `pmarmux_sel=1` with `load_addr` at cycle 1, `pmem_write` cycles 2–4, `pmem_read` cycles 5–7, `mem_resp` at cycle 8, `wb_cnt=1`.
- Write hit: `mem_write=1`, `hit=1` → `datamux_sel=1` and `mem_resp` in the same `CHECK` cycle.
- Reset during `FETCH` cycle 3 → `pmem_read` low within the same cycle, state `IDLE`, counters 0. A later `pmem_resp` is ignored.
- Saturation: `CNT_WIDTH=2`, 5 hits → `hit_cnt=3`. Then `stats_clr` together with a hit → `hit_cnt=0`.

Source files
------------

// File: rtl/cache_l2_control_pkg.sv
// rtl/cache_l2_control_pkg.sv - shared types and select encodings for the L2 cache controller
package cache_l2_types;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        FETCH     = 2'd3
    } l2_ctrl_state_t;

    // pmem address mux: request tag for fetches, victim tag for writebacks
    localparam logic PMAR_REQ_TAG    = 1'b0;
    localparam logic PMAR_VICTIM_TAG = 1'b1;

    // line data mux: fill from pmem, or merged upstream write data
    localparam logic DATA_PMEM   = 1'b0;
    localparam logic DATA_MERGED = 1'b1;

endpackage

// File: rtl/cache_l2_control_sat_counter.sv
// rtl/cache_l2_control_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // clear wins over a same-cycle increment; the count sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cache_l2_control.sv
// rtl/cache_l2_control.sv - L2 cache sequencing FSM: lookup, writeback, fetch and perf counters
import cache_l2_types::*;

module cache_l2_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic                 hit,
    input  logic                 replace,
    input  logic                 dirty,
    output logic                 pmem_we,
    output logic                 pmarmux_sel,
    output logic                 datamux_sel,
    output logic                 load_addr,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 stats_clr,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt,
    output logic [CNT_WIDTH-1:0] wb_cnt
);

    l2_ctrl_state_t state;
    l2_ctrl_state_t state_next;
    logic           miss_pending;
    logic           req;
    logic           hit_inc;
    logic           miss_inc;
    logic           wb_inc;

    assign req = mem_read | mem_write;

    // Strobes are decoded from state so an async reset drops them immediately.
    always_comb begin
        state_next  = state;
        mem_resp    = 1'b0;
        pmem_we     = 1'b0;
        pmarmux_sel = PMAR_REQ_TAG;
        datamux_sel = DATA_PMEM;
        load_addr   = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        wb_inc      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (hit) begin
                    // a simultaneous read+write is a write, which mem_write alone decides
                    mem_resp    = 1'b1;
                    datamux_sel = mem_write ? DATA_MERGED : DATA_PMEM;
                    hit_inc     = ~miss_pending;
                    state_next  = IDLE;
                end else begin
                    load_addr = 1'b1;
                    miss_inc  = 1'b1;
                    if (replace && dirty) begin
                        pmarmux_sel = PMAR_VICTIM_TAG;
                        wb_inc      = 1'b1;
                        state_next  = WRITEBACK;
                    end else begin
                        pmarmux_sel = PMAR_REQ_TAG;
                        state_next  = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    load_addr   = 1'b1;
                    pmarmux_sel = PMAR_REQ_TAG;
                    state_next  = FETCH;
                end
            end
            FETCH: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    pmem_we     = 1'b1;
                    datamux_sel = DATA_PMEM;
                    state_next  = CHECK;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // miss_pending keeps the post-fill re-lookup from counting as a hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            miss_pending <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                miss_pending <= 1'b0;
            end else if (miss_inc) begin
                miss_pending <= 1'b1;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit_inc),
        .clr   (stats_clr),
        .count (hit_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_inc),
        .clr   (stats_clr),
        .count (miss_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wb_inc),
        .clr   (stats_clr),
        .count (wb_cnt)
    );

endmodule
